// File: rtl/lcd_char_arbiter_if.sv
// Handshake bundle between two character producers, the shared draw engine and lcd_char_arbiter.
// master = arbiter view, slave = surrounding controllers / draw engine view.
interface lcd_char_arbiter_if;
    logic       init_done;
    logic       show_char_done;
    logic       req0;
    logic       req1;
    logic [6:0] ascii0;
    logic [6:0] ascii1;
    logic [8:0] x0;
    logic [8:0] x1;
    logic [8:0] y0;
    logic [8:0] y1;
    logic       ack0;
    logic       ack1;
    logic       show_char_flag;
    logic [6:0] ascii_num;
    logic [8:0] start_x;
    logic [8:0] start_y;
    logic       grant;
    logic       busy;
    logic       timeout_err;

    modport master (
        input  init_done, show_char_done,
        input  req0, req1, ascii0, ascii1, x0, x1, y0, y1,
        output ack0, ack1, show_char_flag, ascii_num, start_x, start_y,
        output grant, busy, timeout_err
    );

    modport slave (
        output init_done, show_char_done,
        output req0, req1, ascii0, ascii1, x0, x1, y0, y1,
        input  ack0, ack1, show_char_flag, ascii_num, start_x, start_y,
        input  grant, busy, timeout_err
    );
endinterface

// File: rtl/lcd_char_arbiter.sv
// Shares one LCD character-draw engine between two requesters: grant, issue, wait for done (with timeout), ack.
// Define LCD_CHAR_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module lcd_char_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 24'd2_000_000,
    parameter int unsigned TO_W        = 24
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    lcd_char_arbiter_if.master  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic            last_served;
    logic            winner;
    logic            wait_done;
    logic            wait_expire;

`ifdef LCD_CHAR_ARB_RR_EN
    always_comb begin
        winner = (bus.req0 && bus.req1) ? ~last_served : ~bus.req0;
    end
`else
    logic unused_last_served;
    assign unused_last_served = last_served;

    always_comb begin
        winner = ~bus.req0;
    end
`endif

    // A done in the same cycle as the limit wins over the timeout.
    always_comb begin
        wait_done   = (state == ST_WAIT) && bus.show_char_done;
        wait_expire = (state == ST_WAIT) && !bus.show_char_done && (to_cnt == TO_LAST);
    end

    always_comb begin
        state_nxt = state;
        if (!bus.init_done) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (bus.req0 || bus.req1) state_nxt = ST_ISSUE;
                ST_ISSUE: state_nxt = ST_WAIT;
                ST_WAIT:  if (wait_done || wait_expire) state_nxt = ST_ACK;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so each pulse lines up with its state cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state              <= ST_IDLE;
            to_cnt             <= '0;
            last_served        <= 1'b1;
            bus.show_char_flag <= 1'b0;
            bus.ack0           <= 1'b0;
            bus.ack1           <= 1'b0;
            bus.busy           <= 1'b0;
            bus.timeout_err    <= 1'b0;
            bus.grant          <= 1'b0;
            bus.ascii_num      <= '0;
            bus.start_x        <= '0;
            bus.start_y        <= '0;
        end else begin
            state              <= state_nxt;
            bus.show_char_flag <= (state_nxt == ST_ISSUE);
            bus.busy           <= (state_nxt != ST_IDLE);
            bus.ack0           <= (state_nxt == ST_ACK) && !bus.grant;
            bus.ack1           <= (state_nxt == ST_ACK) && bus.grant;
            bus.timeout_err    <= bus.init_done && wait_expire;

            if ((state == ST_IDLE) && (state_nxt == ST_ISSUE)) begin
                bus.grant     <= winner;
                bus.ascii_num <= winner ? bus.ascii1 : bus.ascii0;
                bus.start_x   <= winner ? bus.x1 : bus.x0;
                bus.start_y   <= winner ? bus.y1 : bus.y0;
            end

            if (state == ST_ISSUE) begin
                to_cnt <= '0;
            end else if (state == ST_WAIT) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (state == ST_ACK) begin
                last_served <= bus.grant;
            end
        end
    end

endmodule
